// File: rtl/aes_key_pkg.sv
// aes_key_pkg: shared AES key-schedule types, round constants, S-box and FSM encoding
package aes_key_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {IDLE, FWD, BWD} state_t;
  localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                       8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction
endpackage

// File: rtl/key_word_func.sv
// key_word_func: key-schedule word function g(x, i) for an Nk-word key
module key_word_func
  import aes_key_pkg::*;
#(
  parameter int Nk = 4
) (
  input  word_t       x,
  input  logic [5:0]  idx,
  output word_t       y
);
  localparam logic [5:0] NKW = 6'(Nk);
  logic [127:0] sb;
  logic unused_hi;
  word_t sub_x, sub_rot;
  sub_bytes u_sb (.din({96'h0, x}), .dout(sb));
  assign unused_hi = ^sb[127:32];
  assign sub_x = sb[31:0];
  // SubWord is bytewise, so rotating after substitution equals SubWord(RotWord(x))
  assign sub_rot = {sub_x[23:0], sub_x[31:24]};
  assign y = (idx % NKW == 6'd0) ? sub_rot ^ {RCON[4'(idx / NKW)], 24'h0}
           : (Nk == 8 && idx % NKW == 6'd4) ? sub_x : x;
endmodule

// File: rtl/sub_bytes.sv
// sub_bytes: AES SubBytes over a 128-bit state, one S-box per byte
module sub_bytes
  import aes_key_pkg::*;
(
  input  logic [127:0] din,
  output logic [127:0] dout
);
  for (genvar b = 0; b < 16; b++) begin : g_sb
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end
endmodule

// File: rtl/inv_key_schedule.sv
// inv_key_schedule: iterative AES key schedule emitting round keys Nr..0 (INV_KEY_ZEROIZE_EN clears key material after the last beat)
module inv_key_schedule
  import aes_key_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_valid,
  output logic            key_ready,
  input  logic [Nk*32-1:0] cipher_key,
  output logic            rk_valid,
  input  logic            rk_ready,
  output logic [127:0]    rk_data,
  output logic [3:0]      rk_round,
  output logic            rk_last
);
  localparam int NR = nr_of(Nk);
  localparam int W = 4 * (NR + 1);
  state_t state;
  word_t win [Nk];
  word_t gx, gy;
  logic [5:0] i, j, gi, r4;
  logic [3:0] r;
  logic [2:0] off;
  logic live, emit, step;
  logic [127:0] rk_next;
  assign key_ready = live && state == IDLE && !rk_valid;
  assign gx = state == FWD ? win[Nk-1] : win[Nk-2];
  assign gi = state == FWD ? i : j + 6'(Nk - 1);
  key_word_func #(.Nk(Nk)) u_g (.x(gx), .idx(gi), .y(gy));
  assign r4 = {r, 2'b00};
  assign off = 3'(r4 - j);
  assign emit = state == BWD && r4 >= j && (!rk_valid || rk_ready);
  assign step = state == BWD && r4 < j;
  // select the four window words that form round key r
  always_comb begin
    rk_next = '0;
    for (int k = 0; k <= Nk - 4; k++) if (int'(off) == k) rk_next = {win[k], win[k+1], win[k+2], win[k+3]};
  end
  // FSM: load key, expand forward to the last word, then emit keys while unwinding the window
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      live <= 1'b0;
      rk_valid <= 1'b0;
      rk_data <= '0;
      rk_round <= '0;
      rk_last <= 1'b0;
      i <= '0;
      j <= '0;
      r <= '0;
      for (int k = 0; k < Nk; k++) win[k] <= '0;
    end else begin
      live <= 1'b1;
      if (rk_valid && rk_ready) rk_valid <= 1'b0;
`ifdef INV_KEY_ZEROIZE_EN
      if (rk_valid && rk_ready && rk_last) begin
        rk_data <= '0;
        rk_round <= '0;
        for (int k = 0; k < Nk; k++) win[k] <= '0;
      end
`endif
      if (state == IDLE && key_valid && key_ready) begin
        for (int k = 0; k < Nk; k++) win[k] <= cipher_key[Nk*32-1-32*k -: 32];
        i <= 6'(Nk);
        state <= FWD;
      end else if (state == FWD) begin
        for (int k = 0; k < Nk - 1; k++) win[k] <= win[k+1];
        win[Nk-1] <= win[0] ^ gy;
        i <= i + 6'd1;
        if (i == 6'(W - 1)) begin
          state <= BWD;
          j <= 6'(W - Nk);
          r <= 4'(NR);
        end
      end else if (emit) begin
        rk_data <= rk_next;
        rk_round <= r;
        rk_valid <= 1'b1;
        rk_last <= r == 4'd0;
        if (r == 4'd0) state <= IDLE;
        else r <= r - 4'd1;
      end else if (step) begin
        for (int k = 1; k < Nk; k++) win[k] <= win[k-1];
        win[0] <= win[Nk-1] ^ gy;
        j <= j - 6'd1;
      end
    end
  end
endmodule

// File: tb/tb_inv_key_schedule.sv
// tb_inv_key_schedule: directed checks of round-key order, values, backpressure and reset
module tb_inv_key_schedule;
  typedef struct packed { logic last; logic [3:0] round; logic [127:0] data; } beat_t;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K6 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K8 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  logic [127:0] fips [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic kv4 = 1'b0, rr4 = 1'b1, kr4, rv4, rl4;
  logic [127:0] key4 = '0, rd4;
  logic [3:0] rn4;
  logic kv6 = 1'b0, kr6, rv6, rl6;
  logic [127:0] rd6;
  logic [3:0] rn6;
  logic kv8 = 1'b0, kr8, rv8, rl8;
  logic [127:0] rd8;
  logic [3:0] rn8;
  inv_key_schedule #(.Nk(4)) dut4 (.clk(clk), .rst(rst), .key_valid(kv4), .key_ready(kr4), .cipher_key(key4),
    .rk_valid(rv4), .rk_ready(rr4), .rk_data(rd4), .rk_round(rn4), .rk_last(rl4));
  inv_key_schedule #(.Nk(6)) dut6 (.clk(clk), .rst(rst), .key_valid(kv6), .key_ready(kr6), .cipher_key(K6),
    .rk_valid(rv6), .rk_ready(1'b1), .rk_data(rd6), .rk_round(rn6), .rk_last(rl6));
  inv_key_schedule #(.Nk(8)) dut8 (.clk(clk), .rst(rst), .key_valid(kv8), .key_ready(kr8), .cipher_key(K8),
    .rk_valid(rv8), .rk_ready(1'b1), .rk_data(rd8), .rk_round(rn8), .rk_last(rl8));
  beat_t q4[$], q6[$], q8[$];
  logic stall4 = 1'b0, unstable4 = 1'b0;
  logic [127:0] sd4 = '0;
  logic [3:0] sn4 = '0;
  int checks = 0, passes = 0, fails = 0;
  // record accepted beats and watch that a stalled beat is held unchanged
  always @(negedge clk) begin
    if (!rst && rv4 && rr4) q4.push_back({rl4, rn4, rd4});
    if (!rst && rv6) q6.push_back({rl6, rn6, rd6});
    if (!rst && rv8) q8.push_back({rl8, rn8, rd8});
    if (!rst && stall4 && !(rv4 && rd4 === sd4 && rn4 === sn4)) unstable4 = 1'b1;
    stall4 = !rst && rv4 && !rr4;
    sd4 = rd4;
    sn4 = rn4;
  end
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send4(input logic [127:0] k);
    check("kr4 before key", {127'b0, kr4}, 128'd1);
    key4 = k;
    kv4 = 1'b1;
    @(posedge clk);
    #1 kv4 = 1'b0;
  endtask
  task automatic wait4(input string tag, input bit bp);
    for (int c = 0; c < 1500 && !kr4; c++) begin
      @(posedge clk);
      #1;
      if (bp) rr4 = 1'($urandom_range(0, 1));
    end
    rr4 = 1'b1;
    check(tag, {127'b0, kr4}, 128'd1);
  endtask
  task automatic check_fips(input string tag);
    check({tag, " count"}, 128'(q4.size()), 128'd11);
    for (int k = 0; k < 11 && k < q4.size(); k++) begin
      check({tag, " data"}, q4[k].data, fips[10-k]);
      check({tag, " round"}, {124'b0, q4[k].round}, 128'(10 - k));
      check({tag, " last"}, {127'b0, q4[k].last}, {127'b0, k == 10});
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    check("rst key_ready", {127'b0, kr4}, 128'd0);
    check("rst rk_valid", {127'b0, rv4}, 128'd0);
    check("rst rk_data", rd4, 128'd0);
    check("rst rk_round", {124'b0, rn4}, 128'd0);
    check("rst rk_last", {127'b0, rl4}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst release key_ready", {127'b0, kr4}, 128'd0);
    @(posedge clk);
    #1;
    check("idle key_ready", {127'b0, kr4}, 128'd1);
    send4(K1);
    wait4("fips done", 1'b0);
    check_fips("fips");
`ifdef INV_KEY_ZEROIZE_EN
    check("zeroized rk_data", rd4, 128'd0);
`else
    check("retained rk_data", rd4, K1);
`endif
    q4.delete();
    send4(K1);
    wait4("bp done", 1'b1);
    check_fips("bp");
    check("bp stable", {127'b0, unstable4}, 128'd0);
    q4.delete();
    send4(K2);
    wait4("k2 done", 1'b0);
    check("k2 count", 128'(q4.size()), 128'd11);
    check("k2 first", q4[0].data, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("k2 last", q4[10].data, K2);
    kv8 = 1'b1;
    @(posedge clk);
    #1 kv8 = 1'b0;
    for (int c = 0; c < 500 && !kr8; c++) @(posedge clk);
    #1;
    check("nk8 done", {127'b0, kr8}, 128'd1);
    check("nk8 count", 128'(q8.size()), 128'd15);
    check("nk8 first", q8[0].data, 128'h24fc79ccbf0979e9371ac23c6d68de36);
    check("nk8 first round", {124'b0, q8[0].round}, 128'd14);
    check("nk8 15th", q8[14].data, K2);
    check("nk8 15th last", {127'b0, q8[14].last}, 128'd1);
    kv6 = 1'b1;
    @(posedge clk);
    #1 kv6 = 1'b0;
    for (int c = 0; c < 500 && !kr6; c++) @(posedge clk);
    #1;
    check("nk6 done", {127'b0, kr6}, 128'd1);
    check("nk6 count", 128'(q6.size()), 128'd13);
    check("nk6 first", q6[0].data, 128'he98ba06f448c773c8ecc720401002202);
    check("nk6 first round", {124'b0, q6[0].round}, 128'd12);
    check("nk6 r0", q6[12].data, 128'h8e73b0f7da0e6452c810f32b809079e5);
    check("nk6 r0 round", {124'b0, q6[12].round}, 128'd0);
    q4.delete();
    send4(K1);
    for (int c = 0; c < 500 && q4.size() < 3; c++) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort rk_valid", {127'b0, rv4}, 128'd0);
    check("abort beats", 128'(q4.size()), 128'd3);
    rst = 1'b0;
    @(posedge clk);
    #1;
    q4.delete();
    send4(K1);
    repeat (5) @(posedge clk);
    #1;
    check("fwd key_ready", {127'b0, kr4}, 128'd0);
    key4 = K2;
    kv4 = 1'b1;
    repeat (3) @(posedge clk);
    #1 kv4 = 1'b0;
    wait4("post rst done", 1'b0);
    check_fips("post rst");
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/inv_key_schedule.md
Name: inv_key_schedule

Overview:
- Iterative AES key schedule for the decryption datapath.
- Accepts the cipher key, expands forward one word per cycle to reach the final round key, then walks the schedule backward one word per cycle.
- Emits round keys in decryption order (Nr down to 0) over a valid/ready stream.
- Only an Nk-word window is held, so no full expanded-key RAM is needed.

Parameters:
- Nk, 4, key length in 32-bit words; legal values 4, 6, 8. Nr = Nk+6; total words W = 4(Nr+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  cipher key offered.
- key_ready  out  1  block idle and able to accept a key.
- cipher_key  in  Nk*32  cipher key; bits [Nk*32-1 -:32] hold w[0].
- rk_valid  out  1  round key present.
- rk_ready  in  1  consumer accepts the round key.
- rk_data  out  128  round key; bits [127:96] hold w[4r].
- rk_round  out  4  round index r of rk_data.
- rk_last  out  1  high with r==0.

Behaviour:
- Reset values: key_ready=0 in the reset cycle, then 1 (IDLE); rk_valid=0, rk_data=0, rk_round=0, rk_last=0; window, j, r cleared.
- Reset mid-operation aborts immediately, and no further rk beat is produced.
- Word function g(x, i):
  - i%Nk==0: SubWord(RotWord(x)) ^ {RCON[i/Nk],24'h0}.
  - Nk==8 and i%Nk==4: SubWord(x).
  - Otherwise: x.
  - RotWord is a one-byte left rotate.
- FSM states: IDLE, FWD, BWD.
- IDLE:
  - key_ready=1.
  - On key_valid&key_ready: window <= w[0..Nk-1], i <= Nk, go to FWD.
  - key_valid is ignored in every other state (key_ready=0).
- FWD:
  - Each cycle computes w[i] = w[i-Nk] ^ g(w[i-1], i), shifts the window up, and increments i.
  - After w[W-1] is computed: go to BWD with j = W-Nk (lowest window index) and r = Nr.
  - Duration is W-Nk cycles: 40, 46, 52 for Nk = 4, 6, 8.
- BWD, one action per cycle in priority order:
  1. If 4r >= j and the slot is free (!rk_valid | rk_ready):
     - Load rk_data with window words at offset 4r-j..4r-j+3, set rk_round=r, rk_valid=1, rk_last=(r==0).
     - If r==0, go to IDLE; otherwise decrement r.
     - No backward step is taken in this cycle.
  2. Else if 4r < j:
     - Recover w[j-1] = w[j-1+Nk] ^ g(w[j-2+Nk], j-1+Nk).
     - Shift the window down and decrement j.
  3. Else stall; the window holds.
- Output stream:
  - rk_data, rk_round and rk_last stay stable while rk_valid & !rk_ready.
  - rk_valid drops after the handshake unless the slot is reloaded in the same cycle.
- The final beat (r==0) may still be pending when IDLE is re-entered. In that case key_ready stays 0 until the beat is accepted.
- BWD minimum duration with rk_ready tied to 1, Nk=4: 51 cycles (11 emits + 40 steps). Total from key accept to rk_last handshake: 91 cycles.
- Zero-latency-bubble throughput is not required.

Optional Feature:
- Macro: INV_KEY_ZEROIZE_EN.
- With the macro defined: on the rk_last handshake, the window registers, rk_data and rk_round are cleared to 0 on the next clock.
- Without it: these registers retain their last values.
- Stream behaviour is identical either way.

Decomposition:
- Package aes_key_pkg holds:
  - RCON table, indices 1..10: 01,02,04,08,10,20,40,80,1b,36.
  - Function nr_of(Nk).
  - Word type (32-bit).
  - FSM state encoding.
- Sub-module key_word_func: combinational g(x, i, Nk). It implements SubWord by instantiating the existing SubBytes on {96'h0, x} and taking the low word.
- inv_key_schedule needs one key_word_func instance, shared between FWD and BWD.

Test Plan:
1. Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
   - First beat r=10 is d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Last beat r=0 equals the key, with rk_last=1.
   - Exactly 11 beats.
2. Nk=4, key 000102…0f: first beat 13111d7fe3944a17f307a78b4d2b30c5. Nk=8, key 000102…1f: first beat r=14 is 24fc79ccbf0979e9371ac23c6d68de36, and the 15th beat equals 000102…0f.
3. Nk=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: 13 beats; the r=0 beat is 8e73b0f7da0e6452c810f32b809079e5; every beat matches a software model.
4. Random rk_ready backpressure (~50%) on case 1:
   - rk_data and rk_round stable while stalled.
   - No beats lost or duplicated.
   - key_ready stays 0 until rk_last is accepted.
5. Assert rst during BWD after 3 beats: rk_valid=0 the next cycle. Then a new key yields a correct full sequence. A key_valid pulse during FWD is ignored.
6. With INV_KEY_ZEROIZE_EN defined: rk_data==0 one cycle after the rk_last handshake. Without it: rk_data retains the cipher-key value.
